// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

    // Width of the uart_tx config port: {fmt[5:0], write_strobe}
    localparam int UART_CFG_W  = 7;
    // Width of the frame format field carried with every requester word
    localparam int UART_FMT_W  = 6;
    // Widest word uart_tx can send
    localparam int UART_DATA_W = 9;

    // Frame format as uart_tx expects it on its config port
    typedef struct packed {
        logic       stop2;
        logic       parity_en;
        logic [3:0] word_size;
    } uart_fmt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_WR,
        ST_CFG_CLR,
        ST_LOAD,
        ST_DRAIN
    } arb_state_e;

    // True when uart_tx must be reprogrammed before sending a word with format fmt
    function automatic logic fmt_changed(input logic cache_vld, input uart_fmt_t cached,
                                         input uart_fmt_t fmt);
        return !cache_vld || (cached != fmt);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping at N-1.
module rr_arbiter #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [ID_W-1:0] grant_idx_o,
    output logic            grant_vld_o
);

    logic [ID_W:0] cand;
    logic          found;

    // Walk the requesters starting at ptr, keep the first one that is asserted
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_i} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N)) begin
                cand = cand - (ID_W+1)'(N);
            end
            if (!found && req_i[cand[ID_W-1:0]]) begin
                found                      = 1'b1;
                grant_o[cand[ID_W-1:0]]    = 1'b1;
                grant_idx_o                = cand[ID_W-1:0];
            end
        end
        grant_vld_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among N_REQ requesters, each with its own frame format.
// The uart_tx config port is rewritten only when the granted format differs from the last one written.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [N_REQ-1:0]                      i_req_valid,
    input  logic [N_REQ-1:0][UART_DATA_W-1:0]     i_req_data,
    input  logic [N_REQ-1:0][UART_FMT_W-1:0]      i_req_config,
    output logic [N_REQ-1:0]                      o_req_ack,
    output logic [UART_CFG_W-1:0]                 o_config,
    output logic [UART_DATA_W-1:0]                o_tx_parallel,
    output logic                                  o_tx_valid,
    input  logic                                  i_tx_ready,
    output logic                                  o_busy,
    output logic [ID_W-1:0]                       o_grant_id
);

    arb_state_e             state_q;
    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        ptr_d;
    logic [ID_W-1:0]        grant_q;
    logic [N_REQ-1:0]       grant_oh_q;
    uart_fmt_t              cache_q;
    logic                   cache_vld_q;
    logic [UART_CFG_W-1:0]  config_q;
    logic [UART_DATA_W-1:0] tx_parallel_q;
    logic                   tx_valid_q;
    logic [N_REQ-1:0]       ack_q;

    logic [N_REQ-1:0]       arb_grant;
    logic [ID_W-1:0]        arb_idx;
    logic                   arb_vld;
    uart_fmt_t              req_fmt_d;

    rr_arbiter #(
        .N(N_REQ)
    ) u_rr_arbiter (
        .req_i       (i_req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .grant_vld_o (arb_vld)
    );

    // Next rr pointer is one past the winner, and the winner's format as a struct
    always_comb begin
        ptr_d     = (arb_idx == ID_W'(N_REQ-1)) ? '0 : arb_idx + ID_W'(1);
        req_fmt_d = uart_fmt_t'(i_req_config[arb_idx]);
    end

    // Arbitration FSM; all outputs to uart_tx and requesters are registered here
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_oh_q    <= '0;
            cache_q       <= '0;
            cache_vld_q   <= 1'b0;
            config_q      <= '0;
            tx_parallel_q <= '0;
            tx_valid_q    <= 1'b0;
            ack_q         <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (i_tx_ready && arb_vld) begin
                        grant_q       <= arb_idx;
                        grant_oh_q    <= arb_grant;
                        ptr_q         <= ptr_d;
                        tx_parallel_q <= i_req_data[arb_idx];
                        if (fmt_changed(cache_vld_q, cache_q, req_fmt_d)) begin
                            config_q    <= {req_fmt_d, 1'b1};
                            cache_q     <= req_fmt_d;
                            cache_vld_q <= 1'b1;
                            state_q     <= ST_CFG_WR;
                        end else begin
                            tx_valid_q  <= 1'b1;
                            state_q     <= ST_LOAD;
                        end
                    end
                end
                ST_CFG_WR: begin
                    config_q <= {config_q[UART_CFG_W-1:1], 1'b0};
                    state_q  <= ST_CFG_CLR;
                end
                ST_CFG_CLR: begin
                    tx_valid_q <= 1'b1;
                    state_q    <= ST_LOAD;
                end
                ST_LOAD: begin
                    // uart_tx drops ready on the baud enable where it takes the word
                    if (!i_tx_ready) begin
                        tx_valid_q <= 1'b0;
                        ack_q      <= grant_oh_q;
                        state_q    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (i_tx_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ack     = ack_q;
    assign o_config      = config_q;
    assign o_tx_parallel = tx_parallel_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_grant_id    = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural uart_tx ready/accept model and a word scoreboard.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N_REQ        = 4;
    localparam int BAUD_WAIT    = 3;
    localparam int FRAME_CYCLES = 12;
    localparam int BUDGET       = 400;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        reqValid;
    logic [N_REQ-1:0][8:0]   reqData;
    logic [N_REQ-1:0][5:0]   reqConfig;
    logic [N_REQ-1:0]        reqAck;
    logic [6:0]              cfgOut;
    logic [8:0]              txParallel;
    logic                    txValid;
    logic                    txReady;
    logic                    busy;
    logic [1:0]              grantId;

    typedef struct {
        logic [1:0] id;
        logic [8:0] data;
        logic [5:0] cfg;
        logic       wr;
    } sbEntry_t;

    sbEntry_t   sbQ[$];
    sbEntry_t   modelEntry;
    int         checks = 0;
    int         errors = 0;
    int         takeCount = 0;
    int         busyCnt = 0;
    int         waitCnt = 0;
    int         cfgPulses = 0;
    logic       holdReady;
    logic       ackPending = 1'b0;
    logic [1:0] ackId = '0;
    logic       cacheVld;
    logic [5:0] cacheCfg;

    uart_tx_arbiter #(
        .N_REQ(N_REQ)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (reqValid),
        .i_req_data    (reqData),
        .i_req_config  (reqConfig),
        .o_req_ack     (reqAck),
        .o_config      (cfgOut),
        .o_tx_parallel (txParallel),
        .o_tx_valid    (txValid),
        .i_tx_ready    (txReady),
        .o_busy        (busy),
        .o_grant_id    (grantId)
    );

    always #5 clk = ~clk;

    // Queue the next expected word, deciding from our own format cache whether a config write must precede it
    function automatic void pushExpected(input logic [1:0] id, input logic [8:0] data, input logic [5:0] cfg);
        sbEntry_t e;
        e.id   = id;
        e.data = data;
        e.cfg  = cfg;
        e.wr   = !cacheVld || (cfg != cacheCfg);
        cacheVld = 1'b1;
        cacheCfg = cfg;
        sbQ.push_back(e);
    endfunction

    // Behavioural uart_tx: takes a word BAUD_WAIT cycles after valid, stays busy FRAME_CYCLES, checks what it took
    always @(negedge clk) begin
        if (!rst_n) begin
            busyCnt    = 0;
            waitCnt    = 0;
            cfgPulses  = 0;
            ackPending = 1'b0;
            txReady    = 1'b0;
        end else begin
            if (ackPending) begin
                checks++;
                if (reqAck !== (4'(1) << ackId)) begin
                    errors++;
                    $display("[TB] FAIL ack_pulse: got %b, expected %b", reqAck, 4'(1) << ackId);
                end
                ackPending = 1'b0;
            end else if (reqAck !== 4'b0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ack: got %b, expected 0000", reqAck);
            end
            if (cfgOut[0] === 1'b1) begin
                cfgPulses++;
                checks++;
                if (sbQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL cfg_write_unexpected: got %b, no word pending", cfgOut);
                end else if (cfgOut[6:1] !== sbQ[0].cfg) begin
                    errors++;
                    $display("[TB] FAIL cfg_write_value: got %b, expected %b", cfgOut, {sbQ[0].cfg, 1'b1});
                end
            end
            if (busyCnt > 0) begin
                busyCnt--;
            end else if (holdReady) begin
                txReady = 1'b0;
            end else if (!txReady) begin
                txReady = 1'b1;
            end else if (txValid === 1'b1) begin
                waitCnt++;
                if (waitCnt >= BAUD_WAIT) begin
                    waitCnt = 0;
                    txReady = 1'b0;
                    busyCnt = FRAME_CYCLES;
                    takeCount++;
                    checks++;
                    if (sbQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL scoreboard_empty: got word %h from id %0d, expected none", txParallel, grantId);
                    end else begin
                        modelEntry = sbQ.pop_front();
                        if (grantId !== modelEntry.id || txParallel !== modelEntry.data || cfgOut[6:1] !== modelEntry.cfg) begin
                            errors++;
                            $display("[TB] FAIL frame_content: got id=%0d data=%h fmt=%b, expected id=%0d data=%h fmt=%b",
                                     grantId, txParallel, cfgOut[6:1], modelEntry.id, modelEntry.data, modelEntry.cfg);
                        end
                        checks++;
                        if (cfgPulses != int'(modelEntry.wr)) begin
                            errors++;
                            $display("[TB] FAIL cfg_write_count: got %0d pulse cycles, expected %0d", cfgPulses, modelEntry.wr);
                        end
                        ackPending = 1'b1;
                        ackId      = modelEntry.id;
                    end
                    cfgPulses = 0;
                end
            end
        end
    end

    // Wait until the arbiter returns to IDLE, flagging a timeout
    task automatic waitIdle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_idle_timeout: busy=%b, expected 0", name, busy);
        end
    endtask

    // Wait for the ack of one requester and then withdraw its request
    task automatic waitAckAndDrop(input int id, input string name);
        int n = 0;
        while (reqAck[id] !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_ack_timeout: ack=%b, expected bit %0d set", name, reqAck, id);
        end
        reqValid[id] = 1'b0;
    endtask

    // Outputs held at zero while reset is asserted
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (reqAck !== '0 || cfgOut !== '0 || txParallel !== '0 || txValid !== 1'b0 ||
            busy !== 1'b0 || grantId !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ack=%b cfg=%b par=%h val=%b busy=%b gid=%0d, expected all 0",
                     reqAck, cfgOut, txParallel, txValid, busy, grantId);
        end
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // First word after reset always writes the config, then loads the word
    task automatic test_first_frame();
        pushExpected(2'd0, 9'h0A5, 6'b10_1000);
        @(negedge clk);
        reqData[0]   = 9'h0A5;
        reqConfig[0] = 6'b10_1000;
        reqValid[0]  = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grantId !== 2'd0 || cfgOut !== 7'b1010001) begin
            errors++;
            $display("[TB] FAIL grant_cfg_wr: got busy=%b gid=%0d cfg=%b, expected 1 0 1010001", busy, grantId, cfgOut);
        end
        @(negedge clk);
        checks++;
        if (cfgOut !== 7'b1010000 || txValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cfg_clr: got cfg=%b val=%b, expected 1010000 0", cfgOut, txValid);
        end
        @(negedge clk);
        checks++;
        if (txValid !== 1'b1 || txParallel !== 9'h0A5) begin
            errors++;
            $display("[TB] FAIL load_word: got val=%b par=%h, expected 1 0a5", txValid, txParallel);
        end
        waitAckAndDrop(0, "first_frame");
        waitIdle("first_frame");
    endtask

    // Same format again goes straight to LOAD with no config strobe
    task automatic test_same_config();
        pushExpected(2'd0, 9'h05A, 6'b10_1000);
        @(negedge clk);
        reqData[0]  = 9'h05A;
        reqValid[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (txValid !== 1'b1 || txParallel !== 9'h05A || cfgOut !== 7'b1010000) begin
            errors++;
            $display("[TB] FAIL no_cfg_load: got val=%b par=%h cfg=%b, expected 1 05a 1010000", txValid, txParallel, cfgOut);
        end
        waitAckAndDrop(0, "same_config");
        waitIdle("same_config");
    endtask

    // All requesters pending with distinct formats: strict 0,1,2,3 with a reconfig before each word
    task automatic test_all_valid();
        int n = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        sbQ.delete();
        cacheVld = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        pushExpected(2'd0, 9'h1FF, 6'b11_1001);
        pushExpected(2'd1, 9'h055, 6'b00_1000);
        pushExpected(2'd2, 9'h03F, 6'b00_0110);
        pushExpected(2'd3, 9'h012, 6'b11_0110);
        reqData[0] = 9'h1FF; reqConfig[0] = 6'b11_1001;
        reqData[1] = 9'h055; reqConfig[1] = 6'b00_1000;
        reqData[2] = 9'h03F; reqConfig[2] = 6'b00_0110;
        reqData[3] = 9'h012; reqConfig[3] = 6'b11_0110;
        reqValid   = 4'hF;
        while (reqValid !== 4'h0 && n < 4 * BUDGET) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N_REQ; i++) begin
                if (reqAck[i] === 1'b1) reqValid[i] = 1'b0;
            end
        end
        if (n >= 4 * BUDGET) begin
            checks++;
            errors++;
            $display("[TB] FAIL all_valid_timeout: valid=%b, expected 0000", reqValid);
            reqValid = '0;
        end
        waitIdle("all_valid");
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL all_valid_drained: got %0d words left, expected 0", sbQ.size());
        end
    endtask

    // Valid withdrawn right after grant: the latched word still goes out exactly once
    task automatic test_drop_after_grant();
        int n = 0;
        int startTakes;
        pushExpected(2'd2, 9'h0C3, 6'b01_0111);
        startTakes = takeCount;
        @(negedge clk);
        reqData[2]   = 9'h0C3;
        reqConfig[2] = 6'b01_0111;
        reqValid[2]  = 1'b1;
        while (busy !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        reqValid[2] = 1'b0;
        reqData[2]  = 9'h1AA;
        reqConfig[2] = 6'b00_0101;
        waitIdle("drop_after_grant");
        repeat (30) @(negedge clk);
        checks++;
        if (takeCount != startTakes + 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_single_frame: got %0d frames busy=%b, expected 1 frame busy=0",
                     takeCount - startTakes, busy);
        end
    endtask

    // Reset in the middle of a frame, uart_tx held not-ready afterwards, then a forced config write
    task automatic test_mid_frame_reset();
        pushExpected(2'd1, 9'h066, 6'b00_1000);
        @(negedge clk);
        reqData[1]   = 9'h066;
        reqConfig[1] = 6'b00_1000;
        reqValid[1]  = 1'b1;
        waitAckAndDrop(1, "pre_reset");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        holdReady = 1'b1;
        sbQ.delete();
        cacheVld = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (reqAck !== '0 || cfgOut !== '0 || txParallel !== '0 || txValid !== 1'b0 ||
                busy !== 1'b0 || grantId !== '0) begin
                errors++;
                $display("[TB] FAIL mid_reset_outputs: got ack=%b cfg=%b par=%h val=%b busy=%b gid=%0d, expected all 0",
                         reqAck, cfgOut, txParallel, txValid, busy, grantId);
            end
        end
        #2 rst_n = 1'b1;
        pushExpected(2'd1, 9'h066, 6'b00_1000);
        reqValid[1] = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || txValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_grant_not_ready: got busy=%b val=%b, expected 0 0", busy, txValid);
        end
        holdReady = 1'b0;
        waitAckAndDrop(1, "post_reset");
        waitIdle("post_reset");
    endtask

    // Requester 1 streams continuously, requester 3 joins late: service alternates 1,3,1,3
    task automatic test_fairness();
        int n = 0;
        int served1 = 0;
        int served3 = 0;
        pushExpected(2'd1, 9'h101, 6'b00_1000);
        pushExpected(2'd3, 9'h1E0, 6'b10_0111);
        pushExpected(2'd1, 9'h102, 6'b00_1000);
        pushExpected(2'd3, 9'h1E1, 6'b10_0111);
        @(negedge clk);
        reqData[1]   = 9'h101;
        reqConfig[1] = 6'b00_1000;
        reqValid[1]  = 1'b1;
        while (busy !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        reqData[3]   = 9'h1E0;
        reqConfig[3] = 6'b10_0111;
        reqValid[3]  = 1'b1;
        n = 0;
        while (reqValid !== 4'h0 && n < 4 * BUDGET) begin
            @(negedge clk);
            n++;
            if (reqAck[1] === 1'b1) begin
                served1++;
                if (served1 == 1) reqData[1] = 9'h102;
                else reqValid[1] = 1'b0;
            end
            if (reqAck[3] === 1'b1) begin
                served3++;
                if (served3 == 1) reqData[3] = 9'h1E1;
                else reqValid[3] = 1'b0;
            end
        end
        if (n >= 4 * BUDGET) begin
            checks++;
            errors++;
            $display("[TB] FAIL fairness_timeout: valid=%b, expected 0000", reqValid);
            reqValid = '0;
        end
        waitIdle("fairness");
        checks++;
        if (sbQ.size() != 0 || served1 != 2 || served3 != 2) begin
            errors++;
            $display("[TB] FAIL fairness_counts: got left=%0d acks1=%0d acks3=%0d, expected 0 2 2",
                     sbQ.size(), served1, served3);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        reqValid  = '0;
        reqData   = '0;
        reqConfig = '0;
        holdReady = 1'b0;
        cacheVld  = 1'b0;
        cacheCfg  = '0;
        test_reset();
        test_first_frame();
        test_same_config();
        test_all_valid();
        test_drop_after_grant();
        test_mid_frame_reset();
        test_fairness();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
